// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - RV32I load/store funct3 encodings and MEM-stage FSM states
package rv32i_types;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_funct3_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DRAIN
   } mem_state_t;

   // Reserved encodings count as misaligned so they never reach the cache.
   function automatic logic funct3_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      logic r;
      r = 1'b0;
      case (funct3)
         3'b011, 3'b110, 3'b111: r = 1'b1;
         default: begin
            if (funct3[1:0] == 2'b01)      r = offset[0];
            else if (funct3[1:0] == 2'b10) r = |offset;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - selects and extends a byte/halfword/word from a 32-bit read word
module load_aligner
   import rv32i_types::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_offset)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

      case (load_funct3_t'(i_funct3))
         LB:      o_load_data = {{24{w_byte[7]}}, w_byte};
         LBU:     o_load_data = {24'h0, w_byte};
         LH:      o_load_data = {{16{w_half[15]}}, w_half};
         LHU:     o_load_data = {16'h0, w_half};
         default: o_load_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage data-cache handshake, lane placement and stall control
// Optional MEM_STAGE_PERF_EN adds perf_accesses / perf_stall_cycles counters.
module mem_stage_ctrl
   import rv32i_types::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   input  logic              kill,
   output logic [ADDR_W-1:0] dmem_address,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic [3:0]        dmem_mbe,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_resp,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall_mem,
   output logic [DATA_W-1:0] load_data,
   output logic              mem_done,
   output logic              misaligned
`ifdef MEM_STAGE_PERF_EN
   ,
   output logic [31:0]       perf_accesses,
   output logic [31:0]       perf_stall_cycles
`endif
);

   mem_state_t        r_state, r_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_mbe;
   logic              r_write;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;

   logic              w_access, w_req;
   logic [ADDR_W-1:0] w_addr;
   logic [3:0]        w_mbe;
   logic [DATA_W-1:0] w_wdata, w_aligned;

   assign w_access   = valid & (mem_read | mem_write);
   assign misaligned = w_access & funct3_misaligned(funct3, addr[1:0]);
   // rst_n in the qualifier keeps the bus quiet while reset is held.
   assign w_req      = w_access & ~misaligned & ~kill & rst_n;
   assign w_addr     = {addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      w_mbe   = 4'hF;
      w_wdata = '0;
      if (mem_write) begin
         case (store_funct3_t'({1'b0, funct3[1:0]}))
            SB: begin
               w_mbe   = 4'b0001 << addr[1:0];
               w_wdata = {4{store_data[7:0]}};
            end
            SH: begin
               w_mbe   = 4'b0011 << addr[1:0];
               w_wdata = {2{store_data[15:0]}};
            end
            default: w_wdata = store_data;
         endcase
      end
   end

   load_aligner u_load_aligner (
      .i_rdata     (dmem_rdata),
      .i_offset    (r_off),
      .i_funct3    (r_funct3),
      .o_load_data (w_aligned)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_mbe    <= '0;
         r_write  <= 1'b0;
         r_funct3 <= '0;
         r_off    <= '0;
      end else begin
         r_state <= r_next;
         if (r_state == IDLE && w_req) begin
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_mbe    <= w_mbe;
            r_write  <= mem_write;
            r_funct3 <= funct3;
            r_off    <= addr[1:0];
         end
      end
   end

   always_comb begin
      r_next       = r_state;
      dmem_address = '0;
      dmem_read    = 1'b0;
      dmem_write   = 1'b0;
      dmem_mbe     = '0;
      dmem_wdata   = '0;
      stall_mem    = 1'b0;
      mem_done     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               dmem_address = w_addr;
               dmem_read    = ~mem_write;
               dmem_write   = mem_write;
               dmem_mbe     = w_mbe;
               dmem_wdata   = w_wdata;
               stall_mem    = 1'b1;
               r_next       = BUSY;
            end
         end
         BUSY, DRAIN: begin
            dmem_address = r_addr;
            dmem_read    = ~r_write;
            dmem_write   = r_write;
            dmem_mbe     = r_mbe;
            dmem_wdata   = r_wdata;
            if (r_state == BUSY) begin
               stall_mem = ~dmem_resp;
               mem_done  = dmem_resp & ~kill;
               if (dmem_resp)  r_next = IDLE;
               else if (kill)  r_next = DRAIN;
            end else begin
               stall_mem = 1'b1;
               if (dmem_resp) r_next = IDLE;
            end
         end
         default: r_next = IDLE;
      endcase
   end

   assign load_data = (mem_done && !r_write) ? w_aligned : '0;

`ifdef MEM_STAGE_PERF_EN
   logic [31:0] r_perf_acc, r_perf_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_acc   <= '0;
         r_perf_stall <= '0;
      end else begin
         if (r_state == IDLE && w_req) r_perf_acc <= r_perf_acc + 32'd1;
         if (stall_mem)                r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_accesses     = r_perf_acc;
   assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register: reads the held load/store fields and runs the data-cache request/response handshake.
- Generates byte enables and store-data lane placement, and aligns and sign-extends load data.
- Drives stall_mem, which gates the load of the EX/MEM and MEM/WB registers until the access completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data-bus width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  EX/MEM entry holds a live instruction
- mem_read  in  1  entry is a load
- mem_write  in  1  entry is a store
- funct3  in  3  access size/sign (RV32I load/store encoding)
- addr  in  ADDR_W  effective address (alu_out)
- store_data  in  DATA_W  rs2 value
- kill  in  1  discard the current MEM instruction's result
- dmem_address  out  ADDR_W  word-aligned address
- dmem_read  out  1  cache read request
- dmem_write  out  1  cache write request
- dmem_mbe  out  4  byte enables
- dmem_wdata  out  DATA_W  lane-shifted store data
- dmem_resp  in  1  cache completion strobe
- dmem_rdata  in  DATA_W  cache read data
- stall_mem  out  1  freeze EX/MEM and upstream registers
- load_data  out  DATA_W  aligned and extended load result
- mem_done  out  1  one-cycle pulse: access completed and result kept
- misaligned  out  1  current entry is misaligned; no access issued

Behaviour:
- Reset is asynchronous and active-low.
- Reset values:
  - state=IDLE; all latched registers 0.
  - All dmem_* outputs 0.
  - stall_mem=0, mem_done=0, load_data=0.
- Request qualifier: req = valid & (mem_read|mem_write) & ~misaligned & ~kill.
- misaligned is combinational:
  - halfword access (funct3[1:0]=01) with addr[0]=1;
  - word access (funct3[1:0]=10) with addr[1:0]≠0.
  - Reserved funct3 values (011, 110, 111) are treated as misaligned.
- State IDLE:
  - dmem_* are driven combinationally from the inputs when req=1.
  - stall_mem=req.
  - On req, latch address, wdata, mbe, rw, funct3 and addr[1:0], then go to BUSY.
  - dmem_resp is ignored in IDLE.
- State BUSY:
  - dmem_* are driven from the latched registers and held stable until dmem_resp.
  - stall_mem = ~dmem_resp.
  - On dmem_resp: mem_done=1, load_data valid (combinational from dmem_rdata), then go to IDLE. stall is low in that cycle, so the pipeline advances at the same edge.
  - kill without dmem_resp: go to DRAIN.
  - kill together with dmem_resp: complete the access with mem_done=0, then go to IDLE.
- State DRAIN:
  - The request stays asserted from the latched registers; the cache cannot abort.
  - stall_mem=1.
  - On dmem_resp: result discarded, mem_done=0, then go to IDLE.
- Byte enables / store data:
  - SB: mbe=4'b0001<<addr[1:0]; wdata=byte replicated ×4.
  - SH: mbe=4'b0011<<addr[1:0]; wdata=halfword replicated ×2.
  - SW: mbe=4'hF.
- Loads:
  - dmem_mbe=4'hF.
  - Select the byte/halfword by the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- load_data is 0 whenever mem_done=0.
- dmem_address = {addr[ADDR_W-1:2],2'b00}.
- A request never issues from a misaligned entry. misaligned follows the inputs and is not latched.

Optional Feature:
- Macro MEM_STAGE_PERF_EN.
- Defined:
  - Adds 32-bit counters perf_accesses and perf_stall_cycles as outputs.
  - perf_accesses increments on each transition to BUSY.
  - perf_stall_cycles increments every cycle stall_mem=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- rv32i_types gets:
  - load_funct3_t (lb, lh, lw, lbu, lhu) and store_funct3_t (sb, sh, sw) enums;
  - mem_state_t {IDLE, BUSY, DRAIN}.
- Natural sub-module: load_aligner, combinational (rdata, offset, funct3 → load_data), reusable by forwarding logic.

Test Plan:
- Load: LB addr=0x1003, rdata=0x80FF_1234, resp after 3 cycles → dmem_address=0x1000; stall_mem high for 3 cycles; mem_done pulse with load_data=0xFFFF_FF80.
- Store: SH addr=0x2002, store_data=0x0000_ABCD → dmem_write=1, mbe=4'b1100, wdata=0xABCD_ABCD; stays stable until resp, then stall drops in the resp cycle.
- Misaligned: LW addr=0x3001 → misaligned=1; dmem_read never asserted; stall_mem=0; mem_done=0.
- Kill: LW, then kill asserted one cycle after issue → DRAIN; dmem_read held until resp; mem_done stays 0; returns to IDLE.
- Back-to-back: LHU 0x4002 (rdata=0xBEEF_0000, result 0x0000_BEEF) followed immediately by SW 0x4008 → second request issues the cycle after the first resp, with no overlap.
- Reset: assert rst_n=0 mid-BUSY → all dmem_* and stall_mem go to 0 asynchronously; state=IDLE; with the feature enabled, the counters are 0.
